// File: rtl/bcd_display_scanner_if.sv
// Digit/decimal-point request bus into the scanner and multiplexed 7-segment drive out of it.
// master = producer of the BCD count and consumer of the display drive; slave = the scanner.
interface bcd_display_scanner_if;
    logic       en;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [3:0] dp_in;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output en, digit0, digit1, digit2, digit3, dp_in,
        input  an, seg, dp
    );

    modport slave (
        input  en, digit0, digit1, digit2, digit3, dp_in,
        output an, seg, dp
    );
endinterface

// File: rtl/bcd_display_scanner.sv
// 4-digit common-anode 7-segment scanner with a per-frame snapshot of the BCD inputs.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros of the snapshot (digit0 never blanked).
module bcd_display_scanner #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clock,
    input  logic                  rst,
    bcd_display_scanner_if.slave  bus
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [3:0] AN_OFF   = 4'b1111;

    logic [PW-1:0]     r_presc;
    logic [1:0]        r_sel;
    logic [3:0][3:0]   r_snap;
    logic [3:0]        r_snap_dp;
    logic              r_primed;
    logic [3:0]        r_an;
    logic [6:0]        r_seg;
    logic              r_dp;

    logic              w_tick;
    logic              w_load;
    logic [3:0][3:0]   w_live;
    logic [3:0]        w_blank;
    logic [3:0]        w_cur_digit;
    logic [3:0]        w_an_next;
    logic [6:0]        w_seg_next;

    // Active-low segment pattern {g,f,e,d,c,b,a}; non-BCD codes show a dash.
    function automatic logic [6:0] decode_bcd(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    assign w_live = {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
    assign w_tick = bus.en && (r_presc == PRESC_MAX);
    // Frame boundary reload, or the very first enabled edge so the display never shows reset zeros for long.
    assign w_load = (w_tick && (r_sel == 2'd3)) || (bus.en && !r_primed);

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_presc <= '0;
            r_sel   <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_sel   <= r_sel + 2'd1;
        end else if (bus.en) begin
            r_presc <= r_presc + PW'(1);
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_snap    <= '0;
            r_snap_dp <= '0;
            r_primed  <= 1'b0;
        end else begin
            if (w_load) begin
                r_snap    <= w_live;
                r_snap_dp <= bus.dp_in;
            end
            if (bus.en) begin
                r_primed <= 1'b1;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is blanked only while every more-significant digit is blanked too.
    assign w_blank[3] = (r_snap[3] == 4'd0);
    assign w_blank[2] = (r_snap[2] == 4'd0) && w_blank[3];
    assign w_blank[1] = (r_snap[1] == 4'd0) && w_blank[2];
    assign w_blank[0] = 1'b0;
`else
    assign w_blank = '0;
`endif

    assign w_cur_digit = r_snap[r_sel];
    assign w_an_next   = ~(4'b0001 << r_sel);
    assign w_seg_next  = w_blank[r_sel] ? SEG_OFF : decode_bcd(w_cur_digit);

    // Output register stage: one cycle behind the scan state.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_OFF;
            r_dp  <= 1'b1;
        end else if (bus.en) begin
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
            r_dp  <= ~r_snap_dp[r_sel];
        end else begin
            r_an  <= AN_OFF;
            r_seg <= SEG_OFF;
            r_dp  <= 1'b1;
        end
    end

    assign bus.an  = r_an;
    assign bus.seg = r_seg;
    assign bus.dp  = r_dp;

endmodule
